// File: rtl/sophon_pkg.sv
// Shared LSU/APB types and helpers for the external-memory path.
package sophon_pkg;

    localparam logic [1:0] LSU_SIZE_B = 2'd0;
    localparam logic [1:0] LSU_SIZE_H = 2'd1;
    localparam logic [1:0] LSU_SIZE_W = 2'd2;

    typedef struct packed {
        logic        req;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [1:0]  size;
        logic [3:0]  amo;
    } lsu_req_t;

    typedef struct packed {
        logic        ack;
        logic        error;
        logic [31:0] rdata;
    } lsu_ack_t;

    typedef struct packed {
        logic [31:0] paddr;
        logic        psel;
        logic        penable;
        logic        pwrite;
        logic [31:0] pwdata;
        logic [3:0]  pstrb;
        logic [2:0]  pprot;
    } apb_req_t;

    typedef struct packed {
        logic        pready;
        logic [31:0] prdata;
        logic        pslverr;
    } apb_rsp_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ACCESS,
        ST_RESP
    } bridge_state_e;

    // Doubleword (size 3) cannot be carried on a 32-bit APB, so it is always rejected.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        logic bad;
        case (size)
            LSU_SIZE_B: bad = 1'b0;
            LSU_SIZE_H: bad = addr_lo[0];
            LSU_SIZE_W: bad = (addr_lo != 2'b00);
            default:    bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/lsu_apb_bridge.sv
// LSU request/ack to APB4 master bridge with illegal-access filter and bus timeout.
//
// state  | meaning
// IDLE   | waiting for lsu_req_i.req; filters AMO/misaligned requests
// SETUP  | APB setup phase, psel=1 penable=0
// ACCESS | APB access phase, waiting for pready or timeout
// RESP   | one-cycle ack pulse back to the LSU
module lsu_apb_bridge
    import sophon_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 256,
    parameter logic [2:0]  PPROT_VAL      = 3'b000,
    parameter int          ADDR_W         = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  lsu_req_t          lsu_req_i,
    output lsu_ack_t          lsu_ack_o,
    output logic [ADDR_W-1:0] paddr_o,
    output logic              psel_o,
    output logic              penable_o,
    output logic              pwrite_o,
    output logic [31:0]       pwdata_o,
    output logic [3:0]        pstrb_o,
    output logic [2:0]        pprot_o,
    input  logic              pready_i,
    input  logic [31:0]       prdata_i,
    input  logic              pslverr_i
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic TO_EN = (TIMEOUT_CYCLES != 0);

    bridge_state_e    state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             ack_q;
    logic             err_q;
    logic [31:0]      rdata_q;
    logic             illegal;

    assign illegal   = (lsu_req_i.amo != 4'h0) || is_misaligned(lsu_req_i.size, lsu_req_i.addr[1:0]);
    assign pprot_o   = PPROT_VAL;
    assign lsu_ack_o = '{ack: ack_q, error: err_q, rdata: rdata_q};

    // Bridge FSM; all APB and ack outputs are registered here so they stay stable per phase.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
            rdata_q   <= '0;
            paddr_o   <= '0;
            psel_o    <= 1'b0;
            penable_o <= 1'b0;
            pwrite_o  <= 1'b0;
            pwdata_o  <= '0;
            pstrb_o   <= '0;
        end else begin
            ack_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (lsu_req_i.req) begin
                        if (illegal) begin
                            state_q <= ST_RESP;
                            ack_q   <= 1'b1;
                            err_q   <= 1'b1;
                            rdata_q <= '0;
                        end else begin
                            state_q  <= ST_SETUP;
                            psel_o   <= 1'b1;
                            paddr_o  <= ADDR_W'(lsu_req_i.addr);
                            pwrite_o <= lsu_req_i.we;
                            pwdata_o <= lsu_req_i.wdata;
                            pstrb_o  <= lsu_req_i.we ? lsu_req_i.strb : 4'b0000;
                        end
                    end
                end
                ST_SETUP: begin
                    state_q   <= ST_ACCESS;
                    penable_o <= 1'b1;
                    cnt_q     <= '0;
                end
                ST_ACCESS: begin
                    if (pready_i) begin
                        state_q   <= ST_RESP;
                        psel_o    <= 1'b0;
                        penable_o <= 1'b0;
                        ack_q     <= 1'b1;
                        err_q     <= pslverr_i;
                        rdata_q   <= pwrite_o ? 32'h0 : prdata_i;
                        cnt_q     <= '0;
                    end else if (TO_EN && (cnt_q == TO_LAST)) begin
                        state_q   <= ST_RESP;
                        psel_o    <= 1'b0;
                        penable_o <= 1'b0;
                        ack_q     <= 1'b1;
                        err_q     <= 1'b1;
                        rdata_q   <= '0;
                        cnt_q     <= '0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_RESP: begin
                    // No relaunch here: upstream still holds req during the ack cycle.
                    state_q <= ST_IDLE;
                    cnt_q   <= '0;
                    err_q   <= 1'b0;
                    rdata_q <= '0;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_apb_bridge.sv
// Self-checking bench for lsu_apb_bridge: vector table, APB slave model, ack scoreboard.
module tb_lsu_apb_bridge;
    import sophon_pkg::*;

    localparam logic [2:0] PPROT = 3'b010;
    localparam logic [31:0] JUNK = 32'hBAD0_BAD0;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    lsu_req_t    lsu_req_i;
    lsu_ack_t    lsu_ack_o;
    logic [31:0] paddr_o;
    logic        psel_o, penable_o, pwrite_o;
    logic [31:0] pwdata_o;
    logic [3:0]  pstrb_o;
    logic [2:0]  pprot_o;
    logic        pready_i;
    logic [31:0] prdata_i;
    logic        pslverr_i;

    lsu_apb_bridge #(.TIMEOUT_CYCLES(8), .PPROT_VAL(PPROT), .ADDR_W(32)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .lsu_req_i(lsu_req_i), .lsu_ack_o(lsu_ack_o),
        .paddr_o(paddr_o), .psel_o(psel_o), .penable_o(penable_o), .pwrite_o(pwrite_o),
        .pwdata_o(pwdata_o), .pstrb_o(pstrb_o), .pprot_o(pprot_o),
        .pready_i(pready_i), .prdata_i(prdata_i), .pslverr_i(pslverr_i)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    int n_chk = 0;
    int n_err = 0;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [1:0]  size;
        logic [3:0]  amo;
        int          waits;
        logic [31:0] prdata;
        logic        slverr;
        logic        exp_err;
        logic [31:0] exp_rdata;
        int          exp_acc;
    } vec_t;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    vec_t vecs[10];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [3:0] strb, input logic [1:0] size, input logic [3:0] amo,
                                input int waits, input logic [31:0] prdata, input logic slverr,
                                input logic exp_err, input logic [31:0] exp_rdata, input int exp_acc);
        vec_t v;
        v.we = we; v.addr = addr; v.wdata = wdata; v.strb = strb; v.size = size; v.amo = amo;
        v.waits = waits; v.prdata = prdata; v.slverr = slverr;
        v.exp_err = exp_err; v.exp_rdata = exp_rdata; v.exp_acc = exp_acc;
        return v;
    endfunction

    // Ack scoreboard: every ack must match the oldest expected response, including its cycle.
    always @(negedge clk_i) begin
        if (!rst_i && lsu_ack_o.ack) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                n_err++;
                $display("FAIL unexpected_ack: got ack at cycle %0d required none", cyc);
            end else begin
                mon_e = exp_q.pop_front();
                chk("ack_error", 32'(lsu_ack_o.error), 32'(mon_e.err));
                chk("ack_rdata", lsu_ack_o.rdata, mon_e.rdata);
                chk("ack_cycle", 32'(cyc), 32'(mon_e.cyc));
            end
        end
    end

    task automatic slave_idle();
        pready_i  = 1'b1;
        pslverr_i = 1'b1;
        prdata_i  = JUNK;
    endtask

    task automatic run_txn(input vec_t v);
        int   c0;
        int   acc;
        int   step;
        bit   done;
        bit   apb_bad;
        bit   seen_psel;
        bit   prev_psel;
        exp_t e;
        @(negedge clk_i);
        lsu_req_i = '{req: 1'b1, we: v.we, addr: v.addr, wdata: v.wdata,
                      strb: v.strb, size: v.size, amo: v.amo};
        slave_idle();
        c0 = cyc;
        e.err = v.exp_err;
        e.rdata = v.exp_rdata;
        e.cyc = c0 + ((v.exp_acc == 0) ? 1 : 2 + v.exp_acc);
        exp_q.push_back(e);
        acc = 0; done = 0; apb_bad = 0; seen_psel = 0; prev_psel = 0;
        for (step = 0; step < 40 && !done; step++) begin
            @(negedge clk_i);
            if (lsu_ack_o.ack) begin
                done = 1;
                slave_idle();
            end else begin
                if (step == 0) begin
                    lsu_req_i.addr  = ~v.addr;
                    lsu_req_i.wdata = ~v.wdata;
                    lsu_req_i.strb  = ~v.strb;
                    lsu_req_i.we    = ~v.we;
                    lsu_req_i.amo   = 4'hF;
                end
                if (psel_o) begin
                    seen_psel = 1;
                    if (paddr_o !== v.addr || pwrite_o !== v.we || pprot_o !== PPROT ||
                        pstrb_o !== (v.we ? v.strb : 4'b0000) || (v.we && pwdata_o !== v.wdata))
                        apb_bad = 1;
                    if (penable_o !== prev_psel) apb_bad = 1;
                end
                prev_psel = psel_o;
                if (psel_o && penable_o) begin
                    acc++;
                    if (acc > v.waits) begin
                        pready_i  = 1'b1;
                        pslverr_i = v.slverr;
                        prdata_i  = v.prdata;
                    end else begin
                        pready_i  = 1'b0;
                        pslverr_i = 1'b1;
                        prdata_i  = JUNK;
                    end
                end else begin
                    slave_idle();
                end
            end
        end
        if (!done) begin
            n_chk++;
            n_err++;
            $display("FAIL ack_timeout: got no ack within 40 cycles required ack at cycle %0d", e.cyc);
            exp_q.delete();
        end
        chk("access_cycles", 32'(acc), 32'(v.exp_acc));
        chk("psel_seen", 32'(seen_psel), 32'(v.exp_acc != 0));
        chk("apb_fields", 32'(apb_bad), 32'd0);
        @(negedge clk_i);
        lsu_req_i.req = 1'b0;
    endtask

    initial begin
        //              we    addr          wdata         strb     size amo  waits prdata        slv  err  rdata         acc
        vecs[0] = mk(1'b0, 32'h0009_0010, 32'h0,        4'b1111, 2'd2, 4'h0, 0,   32'hDEADBEEF, 1'b0, 1'b0, 32'hDEADBEEF, 1);
        vecs[1] = mk(1'b1, 32'h0009_0004, 32'h12345678, 4'b1100, 2'd2, 4'h0, 3,   32'hFFFFFFFF, 1'b0, 1'b0, 32'h0,        4);
        vecs[2] = mk(1'b0, 32'h0009_0020, 32'h0,        4'b0000, 2'd2, 4'h0, 1,   32'hCAFEF00D, 1'b1, 1'b1, 32'hCAFEF00D, 2);
        vecs[3] = mk(1'b0, 32'h0009_0000, 32'h0,        4'b0000, 2'd2, 4'h1, 0,   32'h0,        1'b0, 1'b1, 32'h0,        0);
        vecs[4] = mk(1'b0, 32'h0009_0002, 32'h0,        4'b0000, 2'd2, 4'h0, 0,   32'h0,        1'b0, 1'b1, 32'h0,        0);
        vecs[5] = mk(1'b1, 32'h0009_0001, 32'hAAAA5555, 4'b0011, 2'd1, 4'h0, 0,   32'h0,        1'b0, 1'b1, 32'h0,        0);
        vecs[6] = mk(1'b0, 32'h0009_0000, 32'h0,        4'b0000, 2'd3, 4'h0, 0,   32'h0,        1'b0, 1'b1, 32'h0,        0);
        vecs[7] = mk(1'b0, 32'h0009_0030, 32'h0,        4'b0000, 2'd2, 4'h0, 100, 32'h55555555, 1'b0, 1'b1, 32'h0,        8);
        vecs[8] = mk(1'b0, 32'h0009_0003, 32'h0,        4'b0000, 2'd0, 4'h0, 0,   32'h11223344, 1'b0, 1'b0, 32'h11223344, 1);
        vecs[9] = mk(1'b1, 32'h0009_0006, 32'h0000BEEF, 4'b0011, 2'd1, 4'h0, 2,   32'h77777777, 1'b0, 1'b0, 32'h0,        3);

        lsu_req_i = '0;
        slave_idle();
        repeat (3) @(negedge clk_i);
        chk("rst_psel", 32'(psel_o), 32'd0);
        chk("rst_penable", 32'(penable_o), 32'd0);
        chk("rst_pwrite", 32'(pwrite_o), 32'd0);
        chk("rst_paddr", paddr_o, 32'd0);
        chk("rst_pwdata", pwdata_o, 32'd0);
        chk("rst_pstrb", 32'(pstrb_o), 32'd0);
        chk("rst_ack", 32'(lsu_ack_o.ack), 32'd0);
        chk("rst_error", 32'(lsu_ack_o.error), 32'd0);
        chk("rst_rdata", lsu_ack_o.rdata, 32'd0);
        chk("pprot", 32'(pprot_o), 32'(PPROT));
        rst_i = 1'b0;

        for (int i = 0; i < 10; i++) run_txn(vecs[i]);

        // Reset asserted in the middle of an ACCESS phase against a stalled slave.
        begin
            bit in_access;
            @(negedge clk_i);
            lsu_req_i = '{req: 1'b1, we: 1'b0, addr: 32'h0009_0040, wdata: 32'h0,
                          strb: 4'h0, size: 2'd2, amo: 4'h0};
            pready_i = 1'b0;
            in_access = 0;
            for (int k = 0; k < 10 && !in_access; k++) begin
                @(negedge clk_i);
                pready_i = 1'b0;
                in_access = psel_o && penable_o;
            end
            chk("rst_mid_reached_access", 32'(in_access), 32'd1);
            @(negedge clk_i);
            #1 rst_i = 1'b1;
            #1;
            chk("rst_mid_psel", 32'(psel_o), 32'd0);
            chk("rst_mid_penable", 32'(penable_o), 32'd0);
            chk("rst_mid_ack", 32'(lsu_ack_o.ack), 32'd0);
            lsu_req_i.req = 1'b0;
            slave_idle();
            repeat (2) @(negedge clk_i);
            rst_i = 1'b0;
        end
        run_txn(vecs[0]);
        run_txn(vecs[9]);

        repeat (5) @(negedge clk_i);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
